alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle ALU: it computes add, subtract, AND or OR over WIDTH-bit operands, processing SLICE bits per clock through one reused slice datapath with a registered ripple carry between slices. It is the sequential, width-generic successor to the 16-bit ripple ALU. It sits between an operand producer and a result consumer, each connected by a valid/ready handshake, and trades latency for area at wide WIDTH.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle. NSLICE = WIDTH/SLICE, and NSLICE ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- i0  in  WIDTH  operand A.
- i1  in  WIDTH  operand B.
- op  in  2  operation: 00 ADD, 01 SUB (A + ~B + 1), 10 AND, 11 OR.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block accepts operands; high only in IDLE.
- y  out  WIDTH  result; held stable while out_valid is high.
- cout  out  1  carry out of the MSB for ADD/SUB (SUB: 1 = no borrow); 0 for AND/OR.
- out_valid  out  1  y/cout (and flags) are valid.
- out_ready  in  1  consumer accepts the result.
- zero, neg, ovf  out  1 each  present only with ALU_FLAGS_EN; see Configuration.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE → RUN on in_valid && in_ready:
  - Capture i0, i1 and op into registers.
  - Clear the slice counter cnt.
  - Load the carry register with op[0] (1 for SUB, 0 for ADD). The carry is don't-care for AND/OR.
- RUN, each cycle:
  - The slice sub-module takes bits [cnt*SLICE +: SLICE] of A and B, plus op and the carry register.
  - B is inverted when op[0]=1 and op[1]=0.
  - The slice result is written into the y register at the same bit offset.
  - For ADD/SUB, the carry register takes the slice carry-out.
  - cnt increments.
- RUN → DONE when cnt == NSLICE-1 at the clock edge. cout is registered from the final slice carry; it is forced to 0 for AND/OR.
- DONE → IDLE on out_ready. in_ready rises the cycle after the output handshake. There is no overlap of operations.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Reset (any state, including mid-RUN) aborts the operation. All of the following are 0 on reset: state=IDLE, in_ready (becomes 1 once in IDLE after reset release), out_valid, y, cout, cnt, carry, flags. A partial result is never presented.

## Timing
- Acceptance edge = edge 0. Slice i is computed between edge i and edge i+1.
- out_valid is high after edge NSLICE, so latency is NSLICE cycles. With SLICE=WIDTH, latency is 1.
- out_valid stays high, with y/cout/flags unchanged, until a cycle with out_ready=1. It drops after that edge.
- Minimum initiation interval: NSLICE+2 cycles (RUN, DONE handshake, IDLE accept).
- in_valid and out_ready may be asserted simultaneously in DONE. Only the output handshake takes effect in that cycle.

## Configuration
- ALU_FLAGS_EN defined:
  - zero = (y == 0).
  - neg = y[WIDTH-1].
  - ovf = signed overflow for ADD/SUB, computed from the MSB slice as (carry into MSB) XOR (carry out of MSB); 0 for AND/OR.
  - Flags are registered with y, valid under out_valid, and reset to 0.
- ALU_FLAGS_EN undefined: the zero/neg/ovf ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - Op encoding constants: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - FSM state typedef: IDLE, RUN, DONE.
- Sub-module alu_slice is combinational, parametrised by SLICE:
  - Inputs: a, b, cin, op.
  - Outputs: y, cout, and carry-into-MSB (used for ovf).
  - Instantiated once.
- Top level holds the FSM, counter, operand/result registers and handshake.

## Test plan
- WIDTH=16, SLICE=4: ADD 0xFFFF+0x0001 → y=0x0000, cout=1, out_valid exactly 4 cycles after acceptance; with flags, zero=1.
- SUB 0x0005−0x0007 → y=0xFFFE, cout=0; with flags, neg=1, ovf=0. ADD 0x7FFF+0x0001 → y=0x8000, ovf=1, neg=1.
- AND 0xF0F0,0x3C3C → y=0x3030, cout=0. OR of the same operands → y=0xFCFC, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → y, cout and out_valid stable and in_ready=0 throughout; the in_valid pulse during DONE is ignored. Release → out_valid drops, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously at cnt=2 → out_valid=0, y=0, in_ready=1 after release. A new ADD 0x1234+0x1111 then yields 0x2345.
- SLICE=16, WIDTH=16: ADD 0x8000+0x8000 → y=0x0000, cout=1, latency 1; back-to-back random ops match a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential slice ALU: op encodings and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice; SUB inverts B and relies on the caller's carry-in.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             cMsb
);

  logic [SLICE-1:0] w_bEff;
  logic [SLICE-1:0] w_sum;
  logic             w_carry;

  // The carry into the top bit is recovered from the sum bit, which works for any SLICE.
  always_comb begin
    w_bEff             = (op == OP_SUB) ? ~b : b;
    {w_carry, w_sum}   = {1'b0, a} + {1'b0, w_bEff} + {{SLICE{1'b0}}, cin};
    y                  = w_sum;
    cout               = 1'b0;
    cMsb               = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: begin
        cout = w_carry;
        cMsb = w_sum[SLICE-1] ^ a[SLICE-1] ^ w_bEff[SLICE-1];
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU reusing one SLICE-bit datapath with a registered carry.
// Optional zero/neg/ovf outputs are built when ALU_FLAGS_EN is defined.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_cout;
  logic             r_rstDone;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_off;
  logic [SLICE-1:0] w_sliceA;
  logic [SLICE-1:0] w_sliceB;
  logic [SLICE-1:0] w_sliceY;
  logic             w_sliceCout;
  logic [WIDTH-1:0] w_yNext;
`ifdef ALU_FLAGS_EN
  logic             w_cMsb;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(NSLICE - 1));
  assign w_off    = 32'(r_cnt) * 32'(SLICE);
  assign w_sliceA = SLICE'(r_a >> w_off);
  assign w_sliceB = SLICE'(r_b >> w_off);
  assign w_yNext  = (r_y & ~(SMASK << w_off)) | (WIDTH'(w_sliceY) << w_off);

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a    (w_sliceA),
    .b    (w_sliceB),
    .cin  (r_carry),
    .op   (r_op),
    .y    (w_sliceY),
    .cout (w_sliceCout),
`ifdef ALU_FLAGS_EN
    .cMsb (w_cMsb)
`else
    .cMsb ()
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last)   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // in_ready stays low for the first cycle after reset release, so reset never reads as "ready".
  always_comb begin
    in_ready  = (r_state == IDLE) && r_rstDone;
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstDone <= 1'b0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_y       <= '0;
      r_op      <= OP_ADD;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
`ifdef ALU_FLAGS_EN
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_rstDone <= 1'b1;
      if (r_state == IDLE && w_accept) begin
        r_a     <= i0;
        r_b     <= i1;
        r_op    <= op;
        r_cnt   <= '0;
        r_carry <= op[0];
      end else if (r_state == RUN) begin
        r_y   <= w_yNext;
        r_cnt <= r_cnt + CW'(1);
        if (!r_op[1]) r_carry <= w_sliceCout;
        if (w_last) begin
          r_cout <= !r_op[1] && w_sliceCout;
`ifdef ALU_FLAGS_EN
          r_zero <= (w_yNext == '0);
          r_neg  <= w_yNext[WIDTH-1];
          r_ovf  <= !r_op[1] && (w_cMsb ^ w_sliceCout);
`endif
        end
      end
    end
  end

  assign y    = r_y;
  assign cout = r_cout;
`ifdef ALU_FLAGS_EN
  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a SLICE=4 and a SLICE=16 instance against an arithmetic model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] aIn = '0;
  logic [15:0] bIn = '0;
  logic [1:0]  opIn = 2'b00;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic        curSel = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        iv0, iv1, or0, or1;
  logic        ir0, ir1, ov0, ov1, c0, c1;
  logic [15:0] y0, y1;
  logic        tbInReady, tbOutValid, tbCout;
  logic [15:0] tbY;
`ifdef ALU_FLAGS_EN
  logic        z0, z1, n0, n1, o0, o1;
  logic        tbZero, tbNeg, tbOvf;
`endif

  always #5 clk = ~clk;

  assign iv0 = inValid & ~curSel;
  assign iv1 = inValid & curSel;
  assign or0 = outReady & ~curSel;
  assign or1 = outReady & curSel;
  assign tbInReady  = curSel ? ir1 : ir0;
  assign tbOutValid = curSel ? ov1 : ov0;
  assign tbY        = curSel ? y1 : y0;
  assign tbCout     = curSel ? c1 : c0;
`ifdef ALU_FLAGS_EN
  assign tbZero = curSel ? z1 : z0;
  assign tbNeg  = curSel ? n1 : n0;
  assign tbOvf  = curSel ? o1 : o0;
`endif

  alu_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .i0(aIn), .i1(bIn), .op(opIn),
    .in_valid(iv0), .in_ready(ir0), .y(y0), .cout(c0),
    .out_valid(ov0), .out_ready(or0)
`ifdef ALU_FLAGS_EN
    , .zero(z0), .neg(n0), .ovf(o0)
`endif
  );

  alu_seq #(.WIDTH(16), .SLICE(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .i0(aIn), .i1(bIn), .op(opIn),
    .in_valid(iv1), .in_ready(ir1), .y(y1), .cout(c1),
    .out_valid(ov1), .out_ready(or1)
`ifdef ALU_FLAGS_EN
    , .zero(z1), .neg(n1), .ovf(o1)
`endif
  );

  // Reference: whole-word arithmetic, signed overflow judged from operand/result signs.
  function automatic logic [16:0] refResult(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    case (o)
      2'b00:   refResult = {1'b0, a} + {1'b0, b};
      2'b01:   refResult = {1'b0, a} + {1'b0, 16'hFFFF - b} + 17'd1;
      2'b10:   refResult = {1'b0, a & b};
      default: refResult = {1'b0, a | b};
    endcase
  endfunction

  function automatic logic refOvf(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = refResult(o, a, b) & 17'h0FFFF;
    if (o == 2'b00)      refOvf = (a[15] == b[15]) && (r[15] != a[15]);
    else if (o == 2'b01) refOvf = (a[15] != b[15]) && (r[15] != a[15]);
    else                 refOvf = 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, output int lat);
    int n = 0;
    while (!tbInReady && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("in_ready before accept", 32'(tbInReady), 32'd1);
    aIn = a; bIn = b; opIn = o; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    aIn = 16'($urandom); bIn = 16'($urandom); opIn = 2'($urandom);
    lat = 0;
    while (!tbOutValid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // Full transaction: accept, latency, result, optional backpressure with an ignored in_valid pulse.
  task automatic doOp(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                      input int expLat, input int hold, input bit pulse);
    int lat;
    logic [16:0] r;
    r = refResult(o, a, b);
    applyStimulus(o, a, b, lat);
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("y", 32'(tbY), 32'(r[15:0]));
    checkOutput("cout", 32'(tbCout), 32'(r[16]));
`ifdef ALU_FLAGS_EN
    checkOutput("zero", 32'(tbZero), 32'(r[15:0] == 16'h0));
    checkOutput("neg", 32'(tbNeg), 32'(r[15]));
    checkOutput("ovf", 32'(tbOvf), 32'(refOvf(o, a, b)));
`endif
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 2) begin
        aIn = ~a; bIn = ~b; inValid = 1'b1;
      end
      @(posedge clk); #1;
      inValid = 1'b0;
      checkOutput("hold out_valid", 32'(tbOutValid), 32'd1);
      checkOutput("hold in_ready", 32'(tbInReady), 32'd0);
      checkOutput("hold y", 32'(tbY), 32'(r[15:0]));
      checkOutput("hold cout", 32'(tbCout), 32'(r[16]));
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput("release out_valid", 32'(tbOutValid), 32'd0);
    checkOutput("release in_ready", 32'(tbInReady), 32'd1);
  endtask

  initial begin
    int lat;
    logic [1:0] ro;
    logic [15:0] ra, rb;

    #3;
    checkOutput("reset in_ready", 32'(tbInReady), 32'd0);
    checkOutput("reset out_valid", 32'(tbOutValid), 32'd0);
    checkOutput("reset y", 32'(tbY), 32'd0);
    checkOutput("reset cout", 32'(tbCout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-reset in_ready", 32'(tbInReady), 32'd1);

    doOp(2'b00, 16'hFFFF, 16'h0001, 4, 0, 1'b0);
    doOp(2'b01, 16'h0005, 16'h0007, 4, 0, 1'b0);
    doOp(2'b00, 16'h7FFF, 16'h0001, 4, 0, 1'b0);
    doOp(2'b10, 16'hF0F0, 16'h3C3C, 4, 0, 1'b0);
    doOp(2'b11, 16'hF0F0, 16'h3C3C, 4, 5, 1'b1);
    @(posedge clk); #1;
    checkOutput("pulse ignored", 32'(tbOutValid), 32'd0);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(2'b00, 16'hAAAA, 16'h5555, lat);
    checkOutput("pre-reset latency", 32'(lat), 32'd4);
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    aIn = 16'h9999; bIn = 16'h7777; opIn = 2'b00; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(tbOutValid), 32'd0);
    checkOutput("abort y", 32'(tbY), 32'd0);
    checkOutput("abort in_ready", 32'(tbInReady), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort recovery in_ready", 32'(tbInReady), 32'd1);
    checkOutput("abort recovery out_valid", 32'(tbOutValid), 32'd0);
    doOp(2'b00, 16'h1234, 16'h1111, 4, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom); ra = 16'($urandom); rb = 16'($urandom);
      doOp(ro, ra, rb, 4, $urandom_range(0, 2), 1'b0);
    end

    curSel = 1'b1;
    @(posedge clk); #1;
    doOp(2'b00, 16'h8000, 16'h8000, 1, 0, 1'b0);
    doOp(2'b01, 16'h8000, 16'h0001, 1, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom); ra = 16'($urandom); rb = 16'($urandom);
      doOp(ro, ra, rb, 1, $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
